// File: rtl/multi_main_fsm_pkg.sv
// Shared types and constants for the multicycle CPU control path.
// State encoding, opcodes and datapath select values.
package lib_cpu;

   typedef logic [5:0] OPECODE;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_FETCH   = 4'd1,
      ST_DECODE  = 4'd2,
      ST_MEMADR  = 4'd3,
      ST_MEMRD   = 4'd4,
      ST_MEMWB   = 4'd5,
      ST_MEMWR   = 4'd6,
      ST_EXECUTE = 4'd7,
      ST_ALUWB   = 4'd8,
      ST_BRANCH  = 4'd9,
      ST_ADDIEX  = 4'd10,
      ST_ADDIWB  = 4'd11,
      ST_JUMP    = 4'd12,
      ST_SPARE   = 4'd13
   } MAIN_STATE;

   localparam OPECODE OP_RTYPE = 6'b000000;
   localparam OPECODE OP_J     = 6'b000010;
   localparam OPECODE OP_BEQ   = 6'b000100;
   localparam OPECODE OP_ADDI  = 6'b001000;
   localparam OPECODE OP_LW    = 6'b100011;
   localparam OPECODE OP_SW    = 6'b101011;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10,
      ALU_RSVD  = 2'b11
   } ALU_OP;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH  = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   function automatic logic op_known(input OPECODE o);
      return (o == OP_RTYPE) || (o == OP_J)
          || (o == OP_BEQ)   || (o == OP_ADDI)
          || (o == OP_LW)    || (o == OP_SW);
   endfunction

endpackage

// File: rtl/main_fsm_out_dec.sv
// Control output decode for the main FSM.
// Pure function of the state register, plus mem_ready in FETCH.
module main_fsm_out_dec
   import lib_cpu::*;
(
   input  MAIN_STATE  state,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       branch,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write
);

   // map each state to its datapath controls; unlisted ones stay 0
   always_comb begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_op     = ALU_ADD;
      pc_src     = PCSRC_ALU;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      unique case (state)
         ST_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         ST_DECODE: begin
            alu_src_b = SRCB_IMMSH;
         end
         ST_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         ST_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         ST_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         ST_MEMWR: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         ST_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
         end
         ST_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         ST_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = PCSRC_ALUOUT;
            branch    = 1'b1;
         end
         ST_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         ST_ADDIWB: begin
            reg_write = 1'b1;
         end
         ST_JUMP: begin
            pc_src   = PCSRC_JUMP;
            pc_write = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/multi_main_fsm.sv
// Main sequencing FSM of the multicycle CPU.
// Holds the state register; outputs come from main_fsm_out_dec.
module multi_main_fsm
   import lib_cpu::*;
#(
   parameter int OP_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] op,
   input  logic            mem_ready,
   output logic            mem_req,
   output logic            mem_write,
   output logic            iord,
   output logic            ir_write,
   output logic            pc_write,
   output logic            branch,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      alu_op,
   output logic [1:0]      pc_src,
   output logic            reg_dst,
   output logic            mem_to_reg,
   output logic            reg_write,
   output logic            illegal_op,
   output MAIN_STATE       state
);

   OPECODE opc;

   assign opc = OPECODE'(op);

   // unknown opcode flagged only while DECODE is looking at it
   assign illegal_op = (state == ST_DECODE) && !op_known(opc);

   // state register with next-state selection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE:
               state <= ST_FETCH;
            ST_FETCH:
               if (mem_ready) state <= ST_DECODE;
            ST_DECODE: begin
               if ((opc == OP_LW) || (opc == OP_SW))
                  state <= ST_MEMADR;
               else if (opc == OP_RTYPE)
                  state <= ST_EXECUTE;
               else if (opc == OP_BEQ)
                  state <= ST_BRANCH;
               else if (opc == OP_ADDI)
                  state <= ST_ADDIEX;
               else if (opc == OP_J)
                  state <= ST_JUMP;
               else
                  state <= ST_FETCH;
            end
            ST_MEMADR:
               if (opc == OP_SW) state <= ST_MEMWR;
               else              state <= ST_MEMRD;
            ST_MEMRD:
               if (mem_ready) state <= ST_MEMWB;
            ST_MEMWR:
               if (mem_ready) state <= ST_FETCH;
            ST_EXECUTE:
               state <= ST_ALUWB;
            ST_ADDIEX:
               state <= ST_ADDIWB;
            ST_MEMWB,
            ST_ALUWB,
            ST_ADDIWB,
            ST_BRANCH,
            ST_JUMP:
               state <= ST_FETCH;
            default:
               state <= ST_IDLE;
         endcase
      end
   end

   main_fsm_out_dec u_dec (
      .state      (state),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_write  (mem_write),
      .iord       (iord),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .branch     (branch),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .pc_src     (pc_src),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write)
   );

endmodule

// File: tb/tb_multi_main_fsm.sv
// Self-checking bench for multi_main_fsm.
// Instruction-level model builds the expected per-cycle trace.
module tb_multi_main_fsm;
   import lib_cpu::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mem_ready = 1'b0;
   logic [5:0] op = 6'd0;

   logic       mem_req, mem_write, iord, ir_write, pc_write, branch;
   logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_src;
   MAIN_STATE  state;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multi_main_fsm #(.OP_W(6)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (op),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_write  (mem_write),
      .iord       (iord),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .branch     (branch),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .pc_src     (pc_src),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .illegal_op (illegal_op),
      .state      (state)
   );

   wire [17:0] ctrl = {mem_req, mem_write, iord, ir_write,
                       pc_write, branch, alu_src_a, alu_src_b,
                       alu_op, pc_src, reg_dst, mem_to_reg,
                       reg_write, illegal_op};

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic legal(input logic [5:0] o);
      return o inside {6'b100011, 6'b101011, 6'b000000,
                       6'b000100, 6'b001000, 6'b000010};
   endfunction

   // control word expected in a state, straight from the state table
   function automatic logic [17:0] want(input MAIN_STATE s,
                                        input logic r,
                                        input logic [5:0] o);
      logic mq, mw, io, irw, pcw, br, sa, rd, m2r, rw, il;
      logic [1:0] sb, ao, ps;
      {mq, mw, io, irw, pcw, br, sa, rd, m2r, rw, il} = '0;
      sb = 2'b00; ao = 2'b00; ps = 2'b00;
      case (s)
         ST_FETCH:   begin mq = 1; sb = 2'b01; irw = r; pcw = r; end
         ST_DECODE:  begin sb = 2'b11; il = !legal(o); end
         ST_MEMADR:  begin sa = 1; sb = 2'b10; end
         ST_MEMRD:   begin mq = 1; io = 1; end
         ST_MEMWB:   begin rw = 1; m2r = 1; end
         ST_MEMWR:   begin mq = 1; mw = 1; io = 1; end
         ST_EXECUTE: begin sa = 1; ao = 2'b10; end
         ST_ALUWB:   begin rw = 1; rd = 1; end
         ST_BRANCH:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
         ST_ADDIEX:  begin sa = 1; sb = 2'b10; end
         ST_ADDIWB:  begin rw = 1; end
         ST_JUMP:    begin ps = 2'b10; pcw = 1; end
         default:    begin end
      endcase
      return {mq, mw, io, irw, pcw, br, sa, sb, ao, ps, rd, m2r, rw, il};
   endfunction

   typedef struct {
      MAIN_STATE  st;
      logic       rdy;
      logic [5:0] op;
   } step_t;

   step_t plan[$];

   function automatic logic rnd_bit(input logic tied);
      return tied ? 1'b1 : 1'($urandom_range(1, 0));
   endfunction

   task automatic push(input MAIN_STATE s, input logic r, input logic [5:0] o);
      step_t e;
      e.st = s; e.rdy = r; e.op = o;
      plan.push_back(e);
   endtask

   // expected trace for one instruction with fw fetch waits, mw memory waits
   task automatic add_instr(input logic [5:0] o, input int fw,
                            input int mw, input logic tied);
      for (int i = 0; i < fw; i++) push(ST_FETCH, 1'b0, 6'($urandom));
      push(ST_FETCH, 1'b1, 6'($urandom));
      push(ST_DECODE, rnd_bit(tied), o);
      case (o)
         6'b100011: begin
            push(ST_MEMADR, rnd_bit(tied), o);
            for (int i = 0; i < mw; i++) push(ST_MEMRD, 1'b0, o);
            push(ST_MEMRD, 1'b1, o);
            push(ST_MEMWB, rnd_bit(tied), o);
         end
         6'b101011: begin
            push(ST_MEMADR, rnd_bit(tied), o);
            for (int i = 0; i < mw; i++) push(ST_MEMWR, 1'b0, o);
            push(ST_MEMWR, 1'b1, o);
         end
         6'b000000: begin
            push(ST_EXECUTE, rnd_bit(tied), o);
            push(ST_ALUWB, rnd_bit(tied), o);
         end
         6'b000100: push(ST_BRANCH, rnd_bit(tied), o);
         6'b001000: begin
            push(ST_ADDIEX, rnd_bit(tied), o);
            push(ST_ADDIWB, rnd_bit(tied), o);
         end
         6'b000010: push(ST_JUMP, rnd_bit(tied), o);
         default: begin end
      endcase
   endtask

   // one cycle: drive after posedge, compare at negedge
   task automatic run_one();
      step_t e;
      e = plan.pop_front();
      mem_ready = e.rdy;
      op = e.op;
      @(negedge clk);
      check($sformatf("state_%s", e.st.name()), 32'(state), 32'(e.st));
      check($sformatf("ctrl_%s", e.st.name()), 32'(ctrl),
            32'(want(e.st, e.rdy, e.op)));
      @(posedge clk);
      #1;
   endtask

   task automatic run_plan();
      while (plan.size() > 0) run_one();
   endtask

   function automatic logic [5:0] rnd_op();
      logic [5:0] o;
      case ($urandom_range(6, 0))
         0: o = 6'b100011;
         1: o = 6'b101011;
         2: o = 6'b000000;
         3: o = 6'b000100;
         4: o = 6'b001000;
         5: o = 6'b000010;
         default: begin
            o = 6'($urandom);
            while (legal(o)) o = 6'($urandom);
         end
      endcase
      return o;
   endfunction

   initial begin
      for (int i = 0; i < 3; i++) begin
         mem_ready = 1'($urandom_range(1, 0));
         op = 6'($urandom);
         @(negedge clk);
         check("rst_state", 32'(state), 32'(ST_IDLE));
         check("rst_ctrl", 32'(ctrl), 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mem_ready = 1'b0;
      @(negedge clk);
      check("post_rst_idle", 32'(state), 32'(ST_IDLE));
      @(posedge clk);
      #1;

      add_instr(6'b000000, 0, 0, 1'b1);
      run_plan();
      add_instr(6'b100011, 0, 2, 1'b0);
      run_plan();
      add_instr(6'b000100, 0, 0, 1'b0);
      add_instr(6'b000010, 0, 0, 1'b0);
      run_plan();
      add_instr(6'b111111, 1, 0, 1'b0);
      run_plan();

      for (int n = 0; n < 80; n++) begin
         add_instr(rnd_op(), $urandom_range(2, 0),
                   $urandom_range(3, 0), 1'b0);
         run_plan();
      end

      add_instr(6'b101011, 0, 4, 1'b0);
      while (plan.size() > 0 && plan[0].st != ST_MEMWR) run_one();
      plan.delete();
      mem_ready = 1'b0;
      op = 6'b101011;
      @(negedge clk);
      check("wr_wait_state", 32'(state), 32'(ST_MEMWR));
      check("wr_wait_req", 32'({mem_req, mem_write}), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_state", 32'(state), 32'(ST_IDLE));
      check("arst_req", 32'({mem_req, mem_write}), 32'd0);
      check("arst_ctrl", 32'(ctrl), 32'd0);
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      mem_ready = 1'b0;
      @(negedge clk);
      check("rerel_idle", 32'(state), 32'(ST_IDLE));
      check("rerel_ctrl", 32'(ctrl), 32'd0);
      @(posedge clk);
      #1;
      add_instr(6'b000000, 0, 0, 1'b0);
      run_plan();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
